floo_reduction_combine: RTL and testbench

- Stage directly downstream of the reduction synchroniser.
- Once the synchroniser reports that all expected input routes hold matching reduction flits (sync_valid_i plus in_route_mask_i), this block:
  - pops those routes atomically,
  - folds their payloads with the reduction operator carried in the header,
  - registers one combined flit towards the output route.
- Sits inside the router's reduction path between synchroniser and output arbitration.

---
 rtl/floo_pkg.sv | 55 +++++
 rtl/floo_reduction_alu.sv | 80 ++++++++
 rtl/floo_reduction_combine.sv | 145 ++++++++++++++
 tb/tb_floo_reduction_combine.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floo_pkg.sv
// floo_pkg: shared types and the two-operand reduction operator for the
// reduction path.
package floo_pkg;

    localparam int unsigned RedDataWidth = 64;

    typedef logic [RedDataWidth-1:0] red_data_t;

    typedef enum logic [2:0] {
        RED_ADD   = 3'd0,
        RED_AND   = 3'd1,
        RED_OR    = 3'd2,
        RED_XOR   = 3'd3,
        RED_MIN_U = 3'd4,
        RED_MAX_U = 3'd5,
        RED_MIN_S = 3'd6,
        RED_MAX_S = 3'd7
    } red_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    typedef struct packed {
        red_op_e    red_op;
        logic [4:0] src_id;
        logic [4:0] dst_id;
        logic [3:0] tag;
    } red_hdr_t;

    typedef struct packed {
        red_hdr_t  hdr;
        red_data_t payload;
    } red_flit_t;

    // Two-operand reduction; narrower lanes are widened by the caller so the
    // signed comparisons see the correct sign bit.
    function automatic red_data_t red_apply(red_op_e op, red_data_t a, red_data_t b);
        red_data_t r;
        case (op)
            RED_ADD:   r = a + b;
            RED_AND:   r = a & b;
            RED_OR:    r = a | b;
            RED_XOR:   r = a ^ b;
            RED_MIN_U: r = (a < b) ? a : b;
            RED_MAX_U: r = (a > b) ? a : b;
            RED_MIN_S: r = ($signed(a) < $signed(b)) ? a : b;
            RED_MAX_S: r = ($signed(a) > $signed(b)) ? a : b;
            default:   r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/floo_reduction_alu.sv
// floo_reduction_alu: combinational masked fold of NumRoutes payload lanes
// through a balanced binary tree. Lanes outside the mask, and padding lanes
// up to the next power of two, carry the identity of the operator.
module floo_reduction_alu
    import floo_pkg::*;
#(
    parameter int unsigned NumRoutes = 5,
    parameter int unsigned DataWidth = 64
) (
    input  red_op_e                              op_i,
    input  logic [NumRoutes-1:0]                 mask_i,
    input  logic [NumRoutes-1:0][DataWidth-1:0]  payload_i,
    output logic [DataWidth-1:0]                 result_o
);

    typedef logic [DataWidth-1:0] lane_t;

    localparam int unsigned Levels    = (NumRoutes > 1) ? $clog2(NumRoutes) : 0;
    localparam int unsigned NumLeaves = 1 << Levels;

    logic  signed_op;
    lane_t identity;

    assign signed_op = (op_i == RED_MIN_S) || (op_i == RED_MAX_S);

    // Neutral element of the selected operator at lane width.
    always_comb begin
        identity = '0;
        case (op_i)
            RED_AND, RED_MIN_U: identity = '1;
            RED_MIN_S: begin
                identity                = '1;
                identity[DataWidth-1]   = 1'b0;
            end
            RED_MAX_S: begin
                identity                = '0;
                identity[DataWidth-1]   = 1'b1;
            end
            default:   identity = '0;
        endcase
    end

    function automatic red_data_t widen(lane_t x, logic sgn);
        red_data_t w;
        w = red_data_t'(x);
        for (int b = DataWidth; b < RedDataWidth; b++) begin
            w[b] = sgn & x[DataWidth-1];
        end
        return w;
    endfunction

    function automatic lane_t combine(red_op_e op, logic sgn, lane_t a, lane_t b);
        red_data_t r;
        r = red_apply(op, widen(a, sgn), widen(b, sgn));
        return r[DataWidth-1:0];
    endfunction

    for (genvar l = 0; l <= Levels; l++) begin : g_lvl
        localparam int unsigned Width = NumLeaves >> l;
        lane_t [Width-1:0] vals;
        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < Width; j++) begin : g_lane
                if (j < NumRoutes) begin : g_real
                    assign vals[j] = mask_i[j] ? payload_i[j] : identity;
                end else begin : g_pad
                    assign vals[j] = identity;
                end
            end
        end else begin : g_node
            for (genvar j = 0; j < Width; j++) begin : g_pair
                assign vals[j] = combine(op_i, signed_op,
                                         g_lvl[l-1].vals[2*j],
                                         g_lvl[l-1].vals[2*j+1]);
            end
        end
    end

    assign result_o = g_lvl[Levels].vals[0];

endmodule

// File: rtl/floo_reduction_combine.sv
// floo_reduction_combine: once the synchroniser reports a complete set of
// matching reduction flits, pops all masked routes in one cycle, folds their
// payloads and registers one combined flit towards the output route.
// Optional performance counters are built when FLOO_REDUCTION_PERF_EN is defined.
//
// state    | meaning
// ST_EMPTY | output register holds no flit; a fire fills it
// ST_FULL  | valid_o high; held until ready_i, refilled back-to-back on fire
module floo_reduction_combine
    import floo_pkg::*;
#(
    parameter int unsigned NumRoutes = 5,
    parameter int unsigned Index     = 0,
    parameter int unsigned DataWidth = 64,
    parameter type         flit_t    = red_flit_t
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  flit_t [NumRoutes-1:0] data_i,
    input  logic  [NumRoutes-1:0] valid_i,
    output logic  [NumRoutes-1:0] ready_o,
    input  logic                  sync_valid_i,
    input  logic  [NumRoutes-1:0] in_route_mask_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output flit_t                 data_o
`ifdef FLOO_REDUCTION_PERF_EN
    ,
    output logic [31:0]           red_count_o,
    output logic [31:0]           stall_count_o
`endif
);

    out_state_e                          state_q, state_d;
    flit_t                               data_q, data_d;
    logic                                can_accept;
    logic                                fire;
    red_op_e                             red_op;
    logic [NumRoutes-1:0][DataWidth-1:0] lane_payload;
    logic [DataWidth-1:0]                fold_result;

    // valid_i is already qualified by the synchroniser, and only the reference
    // lane header is forwarded; the remaining input bits are intentionally unread.
    logic unused_inputs;
    assign unused_inputs = ^{valid_i, data_i};

    assign can_accept = (state_q == ST_EMPTY) || ready_i;
    assign fire       = sync_valid_i && (in_route_mask_i != '0) && can_accept;
    assign red_op     = red_op_e'(data_i[Index].hdr.red_op);

    // Gather the payload field of each lane for the fold tree.
    always_comb begin
        lane_payload = '0;
        for (int i = 0; i < NumRoutes; i++) begin
            lane_payload[i] = data_i[i].payload[DataWidth-1:0];
        end
    end

    floo_reduction_alu #(
        .NumRoutes (NumRoutes),
        .DataWidth (DataWidth)
    ) i_alu (
        .op_i      (red_op),
        .mask_i    (in_route_mask_i),
        .payload_i (lane_payload),
        .result_o  (fold_result)
    );

    // Output register state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill on fire, drain on ready_i without a refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (fire) state_d = ST_FULL;
            ST_FULL:  if (ready_i && !fire) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Handshake outputs: every masked route pops together with the fire.
    always_comb begin
        valid_o = (state_q == ST_FULL);
        ready_o = fire ? in_route_mask_i : '0;
    end

    // Capture the reference header and the folded payload on fire.
    always_comb begin
        data_d = data_q;
        if (fire) begin
            data_d.hdr     = data_i[Index].hdr;
            data_d.payload = fold_result;
        end
    end

    // Combined flit register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

`ifdef FLOO_REDUCTION_PERF_EN
    logic [31:0] red_count_q,   red_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Saturating event counters for fires and backpressure cycles.
    always_comb begin
        red_count_d   = red_count_q;
        stall_count_d = stall_count_q;
        if (fire && (red_count_q != '1)) begin
            red_count_d = red_count_q + 32'd1;
        end
        if (valid_o && !ready_i && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            red_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            red_count_q   <= red_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign red_count_o   = red_count_q;
    assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_floo_reduction_combine.sv
// Directed bench for floo_reduction_combine (default parameters).
module tb_floo_reduction_combine;
    import floo_pkg::*;

    localparam int unsigned NR = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    red_flit_t [NR-1:0]   data_i;
    logic      [NR-1:0]   valid_i;
    logic      [NR-1:0]   ready_o;
    logic                 sync_valid;
    logic      [NR-1:0]   mask;
    logic                 valid_o;
    logic                 ready_i;
    red_flit_t            data_o;
`ifdef FLOO_REDUCTION_PERF_EN
    logic [31:0]          red_count;
    logic [31:0]          stall_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    floo_reduction_combine #(
        .NumRoutes (NR),
        .Index     (0),
        .DataWidth (64),
        .flit_t    (red_flit_t)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .data_i          (data_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .sync_valid_i    (sync_valid),
        .in_route_mask_i (mask),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .data_o          (data_o)
`ifdef FLOO_REDUCTION_PERF_EN
        ,
        .red_count_o     (red_count),
        .stall_count_o   (stall_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_lanes(input red_op_e op, input logic [NR-1:0][63:0] p);
        for (int i = 0; i < NR; i++) begin
            data_i[i].hdr.red_op = op;
            data_i[i].hdr.src_id = (i == 0) ? 5'd3 : 5'(i + 8);
            data_i[i].hdr.dst_id = 5'd17;
            data_i[i].hdr.tag    = (i == 0) ? 4'hA : 4'h5;
            data_i[i].payload    = p[i];
        end
    endtask

    function automatic red_hdr_t exp_hdr(input red_op_e op);
        red_hdr_t h;
        h.red_op = op;
        h.src_id = 5'd3;
        h.dst_id = 5'd17;
        h.tag    = 4'hA;
        return h;
    endfunction

    task automatic test_reset();
        rst        = 1'b1;
        sync_valid = 1'b0;
        mask       = '0;
        ready_i    = 1'b0;
        valid_i    = '0;
        data_i     = '0;
        step();
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        total++;
        if (data_o !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
        total++;
        if (ready_o !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready_o); end
`ifdef FLOO_REDUCTION_PERF_EN
        total++;
        if (red_count !== 32'd0 || stall_count !== 32'd0) begin
            bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", red_count, stall_count);
        end
`endif
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        set_lanes(RED_ADD, {64'd0, 64'd0, 64'd30, 64'd20, 64'd10});
        valid_i    = 5'b00111;
        mask       = 5'b00111;
        sync_valid = 1'b1;
        ready_i    = 1'b1;
        settle();
        total++;
        if (ready_o !== 5'b00111) begin bad++; $display("FAIL add_pop: got %b want 00111", ready_o); end
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL add_early_valid: got %b want 0", valid_o); end
        step();
        sync_valid = 1'b0;
        mask       = '0;
        total++;
        if (valid_o !== 1'b1 || data_o.payload !== 64'd60) begin
            bad++; $display("FAIL add_result: got v=%b p=%0d want v=1 p=60", valid_o, data_o.payload);
        end
        total++;
        if (data_o.hdr !== exp_hdr(RED_ADD)) begin
            bad++; $display("FAIL add_hdr: got %h want %h", data_o.hdr, exp_hdr(RED_ADD));
        end
        step();
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL add_drain: got %b want 0", valid_o); end
        step();
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL ready_while_empty: got %b want 0", valid_o); end
    endtask

    task automatic test_min_s();
        set_lanes(RED_MIN_S, {64'd3, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FF9C,
                              64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFFB});
        valid_i    = 5'b11111;
        mask       = 5'b10001;
        sync_valid = 1'b1;
        ready_i    = 1'b1;
        settle();
        total++;
        if (ready_o !== 5'b10001) begin bad++; $display("FAIL mins_pop: got %b want 10001", ready_o); end
        step();
        sync_valid = 1'b0;
        mask       = '0;
        total++;
        if (valid_o !== 1'b1 || data_o.payload !== 64'hFFFF_FFFF_FFFF_FFFB) begin
            bad++; $display("FAIL mins_result: got v=%b p=%h want v=1 p=fffffffffffffffb", valid_o, data_o.payload);
        end
        step();
        valid_i = '0;
    endtask

    task automatic test_ops();
        red_op_e              ops  [12];
        logic [NR-1:0]        msks [12];
        logic [NR-1:0][63:0]  pay  [12];
        logic [63:0]          exps [12];
        logic [NR-1:0][63:0]  common;
        common = {64'd0, 64'hFF00_0000_0000_00FF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h3C, 64'hF0};
        ops[0] = RED_ADD;   exps[0] = 64'hFF00_0000_0000_022B;
        ops[1] = RED_AND;   exps[1] = 64'h30;
        ops[2] = RED_OR;    exps[2] = 64'hFF00_0000_0000_00FF;
        ops[3] = RED_XOR;   exps[3] = 64'hFF00_0000_0000_0033;
        ops[4] = RED_MIN_U; exps[4] = 64'h3C;
        ops[5] = RED_MAX_U; exps[5] = 64'hFF00_0000_0000_00FF;
        ops[6] = RED_MIN_S; exps[6] = 64'hFF00_0000_0000_00FF;
        ops[7] = RED_MAX_S; exps[7] = 64'hF0;
        for (int k = 0; k < 8; k++) begin
            msks[k] = 5'b01011;
            pay[k]  = common;
        end
        ops[8]  = RED_ADD;   msks[8]  = 5'b00011; exps[8]  = 64'd1;
        pay[8]  = {64'd0, 64'd0, 64'd0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        ops[9]  = RED_XOR;   msks[9]  = 5'b01001; exps[9]  = 64'd0;
        pay[9]  = {64'h55, 64'hDEAD_BEEF_0123_4567, 64'h55, 64'h55, 64'hDEAD_BEEF_0123_4567};
        ops[10] = RED_MIN_S; msks[10] = 5'b00100; exps[10] = 64'h1234;
        pay[10] = {64'd0, 64'd0, 64'h1234, 64'd0, 64'd0};
        ops[11] = RED_AND;   msks[11] = 5'b10000; exps[11] = 64'h0F0F;
        pay[11] = {64'h0F0F, 64'd0, 64'd0, 64'd0, 64'd0};
        ready_i = 1'b1;
        valid_i = 5'b11111;
        for (int k = 0; k < 12; k++) begin
            set_lanes(ops[k], pay[k]);
            mask       = msks[k];
            sync_valid = 1'b1;
            settle();
            total++;
            if (ready_o !== msks[k]) begin
                bad++; $display("FAIL op%0d_pop: got %b want %b", k, ready_o, msks[k]);
            end
            step();
            sync_valid = 1'b0;
            total++;
            if (valid_o !== 1'b1 || data_o.payload !== exps[k]) begin
                bad++; $display("FAIL op%0d_result: got v=%b p=%h want v=1 p=%h", k, valid_o, data_o.payload, exps[k]);
            end
            total++;
            if (data_o.hdr !== exp_hdr(ops[k])) begin
                bad++; $display("FAIL op%0d_hdr: got %h want %h", k, data_o.hdr, exp_hdr(ops[k]));
            end
        end
        mask = '0;
        step();
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL ops_drain: got %b want 0", valid_o); end
        valid_i = '0;
    endtask

    task automatic test_back_to_back();
        set_lanes(RED_ADD, {64'd0, 64'd0, 64'd0, 64'd2, 64'd1});
        valid_i    = 5'b00011;
        mask       = 5'b00011;
        sync_valid = 1'b1;
        ready_i    = 1'b1;
        settle();
        total++;
        if (ready_o !== 5'b00011) begin bad++; $display("FAIL bp_first_pop: got %b want 00011", ready_o); end
        step();
        set_lanes(RED_ADD, {64'd0, 64'd0, 64'd0, 64'd6, 64'd5});
        ready_i = 1'b0;
        settle();
        for (int c = 0; c < 4; c++) begin
            total++;
            if (ready_o !== '0 || valid_o !== 1'b1 || data_o.payload !== 64'd3) begin
                bad++;
                $display("FAIL bp_hold%0d: got r=%b v=%b p=%0d want r=00000 v=1 p=3", c, ready_o, valid_o, data_o.payload);
            end
            step();
        end
        ready_i = 1'b1;
        settle();
        total++;
        if (ready_o !== 5'b00011) begin bad++; $display("FAIL bp_release_pop: got %b want 00011", ready_o); end
        step();
        total++;
        if (valid_o !== 1'b1 || data_o.payload !== 64'd11) begin
            bad++; $display("FAIL bp_second: got v=%b p=%0d want v=1 p=11", valid_o, data_o.payload);
        end
        for (int k = 0; k < 3; k++) begin
            set_lanes(RED_ADD, {64'd0, 64'd0, 64'd0, 64'(200 + k), 64'(100 + k)});
            settle();
            total++;
            if (ready_o !== 5'b00011) begin bad++; $display("FAIL b2b%0d_pop: got %b want 00011", k, ready_o); end
            step();
            total++;
            if (valid_o !== 1'b1 || data_o.payload !== 64'(300 + 2 * k)) begin
                bad++; $display("FAIL b2b%0d_result: got v=%b p=%0d want v=1 p=%0d", k, valid_o, data_o.payload, 300 + 2 * k);
            end
        end
        sync_valid = 1'b0;
        mask       = '0;
        step();
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", valid_o); end
        valid_i = '0;
    endtask

    task automatic test_no_pop();
        set_lanes(RED_OR, {64'd5, 64'd4, 64'd3, 64'd2, 64'd1});
        valid_i    = 5'b11111;
        mask       = '0;
        sync_valid = 1'b1;
        ready_i    = 1'b1;
        settle();
        total++;
        if (ready_o !== '0) begin bad++; $display("FAIL mask0_pop: got %b want 00000", ready_o); end
        step();
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL mask0_valid: got %b want 0", valid_o); end
        sync_valid = 1'b0;
        mask       = 5'b11111;
        settle();
        total++;
        if (ready_o !== '0) begin bad++; $display("FAIL nosync_pop: got %b want 00000", ready_o); end
        step();
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL nosync_valid: got %b want 0", valid_o); end
        mask    = '0;
        valid_i = '0;
    endtask

`ifdef FLOO_REDUCTION_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        settle();
        total++;
        if (red_count !== 32'd0 || stall_count !== 32'd0) begin
            bad++; $display("FAIL perf_clear: got %0d/%0d want 0/0", red_count, stall_count);
        end
        step();
        rst = 1'b0;
        step();
        set_lanes(RED_ADD, {64'd0, 64'd0, 64'd0, 64'd2, 64'd1});
        mask       = 5'b00011;
        sync_valid = 1'b1; ready_i = 1'b1; step();
        sync_valid = 1'b0; ready_i = 1'b0; step(); step(); step();
        sync_valid = 1'b1; ready_i = 1'b1; step();
        sync_valid = 1'b0; ready_i = 1'b0; step(); step();
        sync_valid = 1'b1; ready_i = 1'b1; step();
        sync_valid = 1'b0; ready_i = 1'b1; step();
        total++;
        if (red_count !== 32'd3) begin bad++; $display("FAIL perf_red: got %0d want 3", red_count); end
        total++;
        if (stall_count !== 32'd5) begin bad++; $display("FAIL perf_stall: got %0d want 5", stall_count); end
        mask = '0;
    endtask
`endif

    task automatic test_reset_mid();
        set_lanes(RED_XOR, {64'd0, 64'd0, 64'd0, 64'h0F, 64'hF0});
        mask       = 5'b00011;
        sync_valid = 1'b1;
        ready_i    = 1'b1;
        step();
        sync_valid = 1'b0;
        mask       = '0;
        ready_i    = 1'b0;
        step();
        total++;
        if (valid_o !== 1'b1 || data_o.payload !== 64'hFF) begin
            bad++; $display("FAIL midrst_full: got v=%b p=%h want v=1 p=ff", valid_o, data_o.payload);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (valid_o !== 1'b0 || data_o !== '0 || ready_o !== '0) begin
            bad++; $display("FAIL midrst_clear: got v=%b d=%h r=%b want v=0 d=0 r=00000", valid_o, data_o, ready_o);
        end
`ifdef FLOO_REDUCTION_PERF_EN
        total++;
        if (red_count !== 32'd0 || stall_count !== 32'd0) begin
            bad++; $display("FAIL midrst_counters: got %0d/%0d want 0/0", red_count, stall_count);
        end
`endif
        step();
        rst = 1'b0;
        step();
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL midrst_after: got %b want 0", valid_o); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_min_s();
        test_ops();
        test_back_to_back();
        test_no_pop();
`ifdef FLOO_REDUCTION_PERF_EN
        test_perf();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
